// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 single-wire responder and its host-side peers.
package dht11_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStartLow,
    StRespDelay,
    StAckLow,
    StAckHigh,
    StBitLow,
    StBitHigh,
    StEndLow
  } dht11_state_e;

  localparam int unsigned FRAME_BITS = 40;

  // Default protocol timing (microseconds) and clock rate.
  localparam int unsigned DEF_CLK_PER_US       = 100;
  localparam int unsigned DEF_MIN_START_LOW_US = 18000;
  localparam int unsigned DEF_RESP_DELAY_US    = 30;
  localparam int unsigned DEF_ACK_LOW_US       = 80;
  localparam int unsigned DEF_ACK_HIGH_US      = 80;
  localparam int unsigned DEF_BIT_LOW_US       = 50;
  localparam int unsigned DEF_BIT0_HIGH_US     = 28;
  localparam int unsigned DEF_BIT1_HIGH_US     = 70;
  localparam int unsigned DEF_END_LOW_US       = 50;

  // Byte-sum checksum; corrupt flips the LSB so a host can exercise its error path.
  function automatic logic [7:0] frame_chk(input logic [7:0] hum_i, input logic [7:0] hum_d,
                                           input logic [7:0] temp_i, input logic [7:0] temp_d,
                                           input logic corrupt);
    logic [7:0] sum;
    sum = hum_i + hum_d + temp_i + temp_d;
    return sum ^ {7'd0, corrupt};
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// Two-flop synchronizer for the open-drain data line, idling high, with
// registered edge strobes aligned to the cycle the synchronized level changes.
module dht11_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_raw,
  output logic line,
  output logic fall,
  output logic rise
);

  logic meta;

  // Synchronize the raw level and flag transitions of the synchronized output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      line <= 1'b1;
      fall <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= line_raw;
      line <= meta;
      fall <= line & ~meta;
      rise <= ~line & meta;
    end
  end

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor-side responder: waits for a valid host start pulse, answers with
// the ACK handshake and shifts out a 40-bit humidity/temperature frame.
module dht11_sensor_emu
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_PER_US       = DEF_CLK_PER_US,
  parameter int unsigned MIN_START_LOW_US = DEF_MIN_START_LOW_US,
  parameter int unsigned RESP_DELAY_US    = DEF_RESP_DELAY_US,
  parameter int unsigned ACK_LOW_US       = DEF_ACK_LOW_US,
  parameter int unsigned ACK_HIGH_US      = DEF_ACK_HIGH_US,
  parameter int unsigned BIT_LOW_US       = DEF_BIT_LOW_US,
  parameter int unsigned BIT0_HIGH_US     = DEF_BIT0_HIGH_US,
  parameter int unsigned BIT1_HIGH_US     = DEF_BIT1_HIGH_US,
  parameter int unsigned END_LOW_US       = DEF_END_LOW_US
) (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       iEnable,
  input  logic       iBusIn,
  output logic       oDriveLow,
  input  logic [7:0] iHumInt,
  input  logic [7:0] iHumDec,
  input  logic [7:0] iTempInt,
  input  logic [7:0] iTempDec,
  input  logic       iCorruptChk,
  output logic       oBusy,
  output logic       oFrameDone,
  output logic       oShortStart,
  output logic       oCollision
);

  localparam int unsigned MIN_CYC = MIN_START_LOW_US * CLK_PER_US;
  localparam int unsigned MAX_CYC =
      max2(MIN_CYC, max2(RESP_DELAY_US, max2(max2(ACK_LOW_US, ACK_HIGH_US),
           max2(max2(BIT_LOW_US, END_LOW_US), max2(BIT0_HIGH_US, BIT1_HIGH_US)))) * CLK_PER_US);
  localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0] LD_RESP     = CNT_W'(RESP_DELAY_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] LD_ACK_LOW  = CNT_W'(ACK_LOW_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] LD_ACK_HIGH = CNT_W'(ACK_HIGH_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] LD_BIT_LOW  = CNT_W'(BIT_LOW_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] LD_BIT0     = CNT_W'(BIT0_HIGH_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] LD_BIT1     = CNT_W'(BIT1_HIGH_US * CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] LD_END_LOW  = CNT_W'(END_LOW_US * CLK_PER_US - 1);
  localparam logic [5:0]       LAST_BIT    = 6'(FRAME_BITS - 1);

  dht11_state_e            state;
  logic [CNT_W-1:0]        cnt;
  logic [FRAME_BITS-1:0]   frame;
  logic [5:0]              bit_idx;
  logic [1:0]              age;
  logic                    line;
  logic                    line_fall;
  logic                    line_rise;
  logic                    phase_end;
  logic                    collide;

  dht11_line_sync u_sync (
    .clk      (iClk),
    .rst_n    (iRstN),
    .line_raw (iBusIn),
    .line     (line),
    .fall     (line_fall),
    .rise     (line_rise)
  );

  assign phase_end = (cnt == '0);
  // The synchronizer still shows our own drive for two cycles after release.
  assign collide   = (age == 2'd2) && !line;
  assign oBusy     = (state != StIdle) && (state != StStartLow);

  // Protocol sequencer: phase timing, frame shifting and registered bus drive.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state       <= StIdle;
      cnt         <= '0;
      frame       <= '0;
      bit_idx     <= '0;
      age         <= '0;
      oDriveLow   <= 1'b0;
      oFrameDone  <= 1'b0;
      oShortStart <= 1'b0;
      oCollision  <= 1'b0;
    end else begin
      oFrameDone  <= 1'b0;
      oShortStart <= 1'b0;
      oCollision  <= 1'b0;
      if (age != 2'd2) age <= age + 2'd1;
      if (!iEnable) begin
        state     <= StIdle;
        oDriveLow <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            // A falling edge implies the line was seen high here, so a frame
            // never re-arms off the tail of our own drive.
            if (line_fall) begin
              state <= StStartLow;
              cnt   <= '0;
            end
          end
          StStartLow: begin
            if (line_rise) begin
              if (cnt == MIN_CNT) begin
                frame <= {iHumInt, iHumDec, iTempInt, iTempDec,
                          frame_chk(iHumInt, iHumDec, iTempInt, iTempDec, iCorruptChk)};
                state <= StRespDelay;
                cnt   <= LD_RESP;
              end else begin
                oShortStart <= 1'b1;
                state       <= StIdle;
              end
            end else if (cnt != MIN_CNT) begin
              cnt <= cnt + 1'b1;
            end
          end
          StRespDelay: begin
            if (phase_end) begin
              state     <= StAckLow;
              oDriveLow <= 1'b1;
              cnt       <= LD_ACK_LOW;
            end else cnt <= cnt - 1'b1;
          end
          StAckLow: begin
            if (phase_end) begin
              state     <= StAckHigh;
              oDriveLow <= 1'b0;
              cnt       <= LD_ACK_HIGH;
              age       <= '0;
            end else cnt <= cnt - 1'b1;
          end
          StAckHigh: begin
            if (collide) begin
              oCollision <= 1'b1;
              state      <= StIdle;
            end else if (phase_end) begin
              state     <= StBitLow;
              oDriveLow <= 1'b1;
              cnt       <= LD_BIT_LOW;
              bit_idx   <= '0;
            end else cnt <= cnt - 1'b1;
          end
          StBitLow: begin
            if (phase_end) begin
              state     <= StBitHigh;
              oDriveLow <= 1'b0;
              cnt       <= frame[FRAME_BITS-1] ? LD_BIT1 : LD_BIT0;
              age       <= '0;
            end else cnt <= cnt - 1'b1;
          end
          StBitHigh: begin
            if (collide) begin
              oCollision <= 1'b1;
              state      <= StIdle;
            end else if (phase_end) begin
              oDriveLow <= 1'b1;
              frame     <= {frame[FRAME_BITS-2:0], 1'b0};
              if (bit_idx == LAST_BIT) begin
                state <= StEndLow;
                cnt   <= LD_END_LOW;
              end else begin
                state   <= StBitLow;
                cnt     <= LD_BIT_LOW;
                bit_idx <= bit_idx + 6'd1;
              end
            end else cnt <= cnt - 1'b1;
          end
          StEndLow: begin
            if (phase_end) begin
              state      <= StIdle;
              oDriveLow  <= 1'b0;
              oFrameDone <= 1'b1;
            end else cnt <= cnt - 1'b1;
          end
          default: begin
            state     <= StIdle;
            oDriveLow <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Directed bench for the DHT11 responder: plays the host, decodes the returned
// frame from bus timing and checks it against a byte scoreboard.
module tb_dht11_sensor_emu;

  localparam int unsigned CLK_US  = 2;
  localparam int unsigned MIN_US  = 100;
  localparam int          MIN_CYC = MIN_US * CLK_US;
  localparam int          LAT     = 30 * CLK_US + 3;   // 2 sync flops + 1 sequencer edge
  localparam int          ACK_CYC = 80 * CLK_US;
  localparam int          BL_CYC  = 50 * CLK_US;
  localparam int          END_CYC = 50 * CLK_US;
  localparam int          THRESH  = (28 + 70) * CLK_US / 2;
  localparam int          ACT_NONE = 0, ACT_MUT = 1, ACT_DIS = 2, ACT_COLL = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       host_low;
  logic       corrupt;
  logic [7:0] hum_i, hum_d, temp_i, temp_d;
  logic       drive_low, busy, frame_done, short_start, collision;
  logic       bus_in;

  int vectors = 0;
  int fails   = 0;
  int done_cnt = 0, short_cnt = 0, coll_cnt = 0, drive_cnt = 0;
  int exp_q[$];

  assign bus_in = !(host_low || drive_low);

  dht11_sensor_emu #(
    .CLK_PER_US       (CLK_US),
    .MIN_START_LOW_US (MIN_US)
  ) dut (
    .iClk        (clk),
    .iRstN       (rst_n),
    .iEnable     (en),
    .iBusIn      (bus_in),
    .oDriveLow   (drive_low),
    .iHumInt     (hum_i),
    .iHumDec     (hum_d),
    .iTempInt    (temp_i),
    .iTempDec    (temp_d),
    .iCorruptChk (corrupt),
    .oBusy       (busy),
    .oFrameDone  (frame_done),
    .oShortStart (short_start),
    .oCollision  (collision)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done)  done_cnt  <= done_cnt + 1;
    if (short_start) short_cnt <= short_cnt + 1;
    if (collision)   coll_cnt  <= coll_cnt + 1;
    if (drive_low)   drive_cnt <= drive_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_frame(input int a, input int b, input int c, input int d, input int cor);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
    exp_q.push_back(((a + b + c + d) % 256) ^ cor);
  endtask

  task automatic host_pulse(input int cycles);
    @(posedge clk); #1 host_low = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 host_low = 1'b0;
  endtask

  // Counts clock edges until drive_low leaves level lvl (sampled 1 ns after each edge).
  task automatic count_while(input logic lvl, input int budget, output int n);
    n = 0;
    while (drive_low === lvl && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Called right after the host releases the line; decodes the reply.
  task automatic decode_frame(input int action, input int act_bit);
    int n, d0, c0;
    logic [7:0] b;
    d0 = done_cnt;
    n = 0;
    while (!drive_low && n < LAT + 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("resp_latency", n, LAT);
    if (!drive_low) return;
    count_while(1'b1, ACK_CYC + 50, n);
    check("ack_low_len", n, ACK_CYC);
    count_while(1'b0, ACK_CYC + 50, n);
    check("ack_high_len", n, ACK_CYC);
    b = '0;
    for (int i = 0; i < 40; i++) begin
      if (action == ACT_DIS && i == act_bit) begin
        en = 1'b0;
        @(posedge clk); #1;
        check("dis_drive", drive_low, 0);
        check("dis_busy", busy, 0);
        repeat (20) @(posedge clk);
        #1 check("dis_no_done", done_cnt, d0);
        en = 1'b1;
        return;
      end
      if (action == ACT_MUT && i == act_bit) hum_i = 8'd99;
      count_while(1'b1, BL_CYC + 50, n);
      if (i == 0) check("bit_low_len", n, BL_CYC);
      if (action == ACT_COLL && i == act_bit) begin
        c0 = coll_cnt;
        repeat (10) @(posedge clk);
        #1 host_low = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("coll_pulse", coll_cnt, c0 + 1);
        check("coll_drive", drive_low, 0);
        check("coll_busy", busy, 0);
        host_low = 1'b0;
        repeat (10) @(posedge clk);
        return;
      end
      count_while(1'b0, 200 * CLK_US, n);
      b = {b[6:0], (n > THRESH)};
      if (i % 8 == 7) begin
        check($sformatf("byte%0d", i / 8), int'(b),
              (exp_q.size() != 0) ? exp_q.pop_front() : -1);
      end
    end
    count_while(1'b1, END_CYC + 50, n);
    check("end_low_len", n, END_CYC);
    @(posedge clk); #1;
    check("frame_done_once", done_cnt, d0 + 1);
    check("busy_after_frame", busy, 0);
  endtask

  initial begin
    int s0, d0;
    rst_n = 1'b0; en = 1'b1; host_low = 1'b0; corrupt = 1'b0;
    hum_i = 8'd0; hum_d = 8'd0; temp_i = 8'd0; temp_d = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_drive", drive_low, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_short", short_start, 0);
    check("rst_coll", collision, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Nominal frame 44/0/23/0.
    hum_i = 8'd44; hum_d = 8'd0; temp_i = 8'd23; temp_d = 8'd0;
    push_frame(44, 0, 23, 0, 0);
    host_pulse(2 * MIN_CYC);
    decode_frame(ACT_NONE, 0);
    check("sb_drained1", exp_q.size(), 0);

    // Host start too short.
    s0 = short_cnt; d0 = drive_cnt;
    host_pulse(MIN_CYC / 2);
    repeat (LAT + 20) @(posedge clk);
    #1;
    check("short_pulse", short_cnt, s0 + 1);
    check("short_no_drive", drive_cnt, d0);
    check("short_idle", busy, 0);

    // Corrupted checksum 51/0/26/0.
    corrupt = 1'b1;
    hum_i = 8'd51; temp_i = 8'd26;
    push_frame(51, 0, 26, 0, 1);
    host_pulse(2 * MIN_CYC);
    decode_frame(ACT_NONE, 0);
    corrupt = 1'b0;

    // Input change mid-frame must not leak into the frame.
    hum_i = 8'd44; temp_i = 8'd23;
    push_frame(44, 0, 23, 0, 0);
    host_pulse(2 * MIN_CYC);
    decode_frame(ACT_MUT, 5);
    hum_i = 8'd44;

    // Disable during bit 10.
    push_frame(44, 0, 23, 0, 0);
    host_pulse(2 * MIN_CYC);
    decode_frame(ACT_DIS, 10);
    exp_q.delete();
    repeat (10) @(posedge clk);

    // Collision during bit 3 released phase.
    push_frame(44, 0, 23, 0, 0);
    host_pulse(2 * MIN_CYC);
    decode_frame(ACT_COLL, 3);
    exp_q.delete();

    // Async reset during ACK low takes effect between edges.
    host_pulse(2 * MIN_CYC);
    for (int k = 0; k < LAT + 50 && !drive_low; k++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_ack", drive_low, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_drive", drive_low, 0);
    check("async_rst_busy", busy, 0);
    #4 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Recovery frame after reset.
    hum_i = 8'd51; temp_i = 8'd26;
    push_frame(51, 0, 26, 0, 0);
    host_pulse(2 * MIN_CYC);
    decode_frame(ACT_NONE, 0);
    check("sb_drained_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/dht11_sensor_emu.md
Name: dht11_sensor_emu

Overview:
Synthesizable DHT11 sensor-side responder. It is the slave end of the single-wire protocol the dht11 controller initiates. It detects the host start pulse, answers with ACK, then sends a 40-bit frame (hum_i, hum_d, temp_i, temp_d, checksum). Used for on-board loopback against the dht11 controller and as an RTL sensor model in Top-level benches.

Parameters:
CLK_PER_US, 100, clock cycles per microsecond (100MHz).
MIN_START_LOW_US, 18000, minimum host low time accepted as a valid start.
RESP_DELAY_US, 30, gap after host release before ACK low.
ACK_LOW_US, 80, sensor ACK low time.
ACK_HIGH_US, 80, sensor ACK high (released) time.
BIT_LOW_US, 50, low preamble of every data bit.
BIT0_HIGH_US, 28, released time encoding a 0.
BIT1_HIGH_US, 70, released time encoding a 1.
END_LOW_US, 50, trailing low after bit 39.

Ports:
iClk  in  1  system clock
iRstN  in  1  asynchronous reset, active-low
iEnable  in  1  responder enabled; low = never drive the bus
iBusIn  in  1  raw bus level (pulled-up line), asynchronous
oDriveLow  out  1  1 = pull bus low, 0 = release (Top: io = oDriveLow ? 0 : z)
iHumInt  in  8  humidity integer byte
iHumDec  in  8  humidity decimal byte
iTempInt  in  8  temperature integer byte
iTempDec  in  8  temperature decimal byte
iCorruptChk  in  1  1 = send checksum XOR 8'h01
oBusy  out  1  high in any state except IDLE and START_LOW
oFrameDone  out  1  1-cycle pulse when END_LOW completes
oShortStart  out  1  1-cycle pulse when a low shorter than MIN_START_LOW_US ends
oCollision  out  1  1-cycle pulse when the bus reads low while the sensor has it released mid-frame

Behaviour:
- Reset (async, iRstN=0): every output 0, state IDLE, sync flops = 1, counters 0. oDriveLow drops to 0 without waiting for a clock edge.
- iBusIn passes through a 2-FF synchronizer, reset value 1. All decisions use the synchronized level.
- Phase counter counts in clocks. A phase of N us lasts exactly N*CLK_PER_US cycles, loaded as N*CLK_PER_US-1 and counted down to 0.
- IDLE: on a synchronized low with iEnable=1, go to START_LOW and clear the low counter.
- START_LOW: count the low time; the counter saturates at MIN_START_LOW_US*CLK_PER_US. When the bus goes high:
  - count reached the minimum: latch snapshot {hum_i, hum_d, temp_i, temp_d, chk} and go to RESP_DELAY.
  - otherwise: pulse oShortStart and go to IDLE.
  - An indefinite host low is legal; the block keeps waiting.
- chk = (hum_i + hum_d + temp_i + temp_d) mod 256, XOR 8'h01 when iCorruptChk was 1 at snapshot time.
- Input changes after the snapshot do not affect the frame in flight.
- Phase sequence: RESP_DELAY (released) -> ACK_LOW (drive) -> ACK_HIGH (released) -> BIT_LOW (drive) -> BIT_HIGH (released; length from current bit) -> ... 40 bits, MSB first, byte order hum_i, hum_d, temp_i, temp_d, chk -> END_LOW (drive) -> IDLE with oFrameDone.
- Bit index 0..39. After bit 39's BIT_HIGH, go to END_LOW, not BIT_LOW.
- oDriveLow is registered and equals 1 exactly in ACK_LOW, BIT_LOW and END_LOW.
- Collision: in ACK_HIGH or BIT_HIGH, a synchronized low seen more than 2 cycles after entering the phase (to skip sync lag from its own release) pulses oCollision. The block then releases the bus and goes to IDLE.
- iEnable=0 in any state: next clock oDriveLow=0 and state IDLE. No oFrameDone pulse.
- The line is not re-armed until it has been high in IDLE; back-to-back frames need a new host start.

Decomposition:
- dht11_pkg: state encoding (IDLE, START_LOW, RESP_DELAY, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW), FRAME_BITS=40, default timing constants.
- One sub-module: dht11_line_sync (2-FF synchronizer, reset-high, plus registered fall/rise strobes). Reused by the host controller.

Test Plan (CLK_PER_US=100, MIN_START_LOW_US=1000):
- Inputs 44/0/23/0: bench drives low 1ms then releases -> oDriveLow rises 3000 cycles (+2 sync) after release, 8000-cycle ACK low/high, decoded bytes 44, 0, 23, 0, 67; oFrameDone pulses once.
- Host low 500us then release -> oDriveLow stays 0, oShortStart pulses once, state IDLE.
- iCorruptChk=1, inputs 51/0/26/0 -> checksum byte 76 (77^1); payload bytes unchanged.
- Change iHumInt 44->99 during bit 5 -> frame still carries 44, checksum 67.
- iEnable deasserted in bit 10 -> oDriveLow 0 next cycle, IDLE, no oFrameDone. Separately, iRstN low during ACK_LOW -> oDriveLow 0 before the next edge.
- Top loopback with the dht11 controller (sped-up params), inputs 51/0/26/0, button C -> controller data-valid set, Hum=51, Temp=26. Bench forcing low during bit 3's BIT_HIGH -> oCollision pulse, bus released.
